// File: rtl/thermo_spi_pkg.sv
// Shared definitions for the thermocouple SPI read path: controller states,
// default frame timing and the field layout of the 32-bit converter word.
package thermo_spi_pkg;

    // Frame sequencing states of the SPI read master
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } spi_state_t;

    // Default frame timing, in clk cycles
    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_CS_SETUP = 2;
    localparam int DEF_CS_HOLD  = 2;
    localparam int DEF_CS_IDLE  = 4;
    localparam int DEF_NBITS    = 32;

    // Field positions inside the converter word, shared with the decoder
    localparam int TC_MSB    = 31;
    localparam int TC_LSB    = 18;
    localparam int FAULT_BIT = 16;
    localparam int JT_MSB    = 15;
    localparam int JT_LSB    = 4;

    // Summary fault bit followed by the three individual fault flags
    function automatic logic [3:0] fault_bits(input logic [31:0] frame);
        return {frame[FAULT_BIT], frame[2:0]};
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock generator: while enabled, toggles sclk every CLK_DIV cycles,
// starting low, and flags the cycle on whose closing edge sclk rises or falls.
module spi_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_sclk,
    output logic o_rise,
    output logic o_fall
);

    localparam int HC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [HC_W-1:0] r_hc;
    logic            r_sclk;
    logic            w_tick;

    // Last cycle of the current half period
    assign w_tick = (r_hc == HC_W'(CLK_DIV - 1));

    // Strobes mark the edge that will move sclk, so the FSM acts on that same edge
    assign o_rise = i_en & w_tick & ~r_sclk;
    assign o_fall = i_en & w_tick &  r_sclk;
    assign o_sclk = r_sclk;

    // Half-period counter and sclk toggle; parked low whenever not enabled
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || !i_en) begin
            r_hc   <= '0;
            r_sclk <= 1'b0;
        end else if (w_tick) begin
            r_hc   <= '0;
            r_sclk <= ~r_sclk;
        end else begin
            r_hc   <= r_hc + 1'b1;
        end
    end

endmodule

// File: rtl/max31855_spi_master.sv
// Read-only SPI master for a MAX31855-style converter (mode 0, MSB first).
// On request it runs one frame, captures the word atomically and pulses rx_done.
module max31855_spi_master
    import thermo_spi_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int CS_SETUP = DEF_CS_SETUP,
    parameter int CS_HOLD  = DEF_CS_HOLD,
    parameter int CS_IDLE  = DEF_CS_IDLE,
    parameter int NBITS    = DEF_NBITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spi_ena,
    output logic             spi_not_busy,
    output logic [NBITS-1:0] spi_rx_data,
    output logic             rx_done,
    output logic             sclk,
    output logic             cs_n,
    input  logic             miso
);

    localparam int CNT_W = 16;
    localparam int BC_W  = (NBITS > 1) ? $clog2(NBITS) : 1;

    spi_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [BC_W-1:0]  r_bit_cnt;
    logic [NBITS-1:0] r_shift;
    logic [NBITS-1:0] r_rx_data;
    logic             r_not_busy;
    logic             r_rx_done;
    logic             r_cs_n;

    logic             w_sclk_en;
    logic             w_sclk;
    logic             w_rise;
    logic             w_fall;

    assign w_sclk_en = (r_state == SHIFT);

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_en    (w_sclk_en),
        .o_sclk  (w_sclk),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign spi_not_busy = r_not_busy;
    assign spi_rx_data  = r_rx_data;
    assign rx_done      = r_rx_done;
    assign sclk         = w_sclk;
    assign cs_n         = r_cs_n;

    // Frame sequencer: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE, all outputs registered
    always_ff @(posedge clk) begin
        r_rx_done <= 1'b0;
        if (!rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_rx_data  <= '0;
            r_not_busy <= 1'b1;
            r_cs_n     <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cs_n     <= 1'b1;
                    r_not_busy <= 1'b1;
                    r_cnt      <= '0;
                    r_bit_cnt  <= '0;
                    if (spi_ena) begin
                        r_state    <= SETUP;
                        r_cs_n     <= 1'b0;
                        r_not_busy <= 1'b0;
                    end
                end
                SETUP: begin
                    if (r_cnt == CNT_W'(CS_SETUP - 1)) begin
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    // Device data is stable at the rising sclk edge; first bit lands in the MSB
                    if (w_rise) begin
                        r_shift <= {r_shift[NBITS-2:0], miso};
                    end
                    // A bit period ends on the falling edge; the last one leaves sclk low
                    if (w_fall) begin
                        if (r_bit_cnt == BC_W'(NBITS - 1)) begin
                            r_bit_cnt <= '0;
                            r_state   <= HOLD;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (r_cnt == CNT_W'(CS_HOLD - 1)) begin
                        r_cnt     <= '0;
                        r_cs_n    <= 1'b1;
                        r_rx_data <= r_shift;
                        r_rx_done <= 1'b1;
                        r_state   <= GAP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (r_cnt == CNT_W'(CS_IDLE - 1)) begin
                        r_cnt      <= '0;
                        r_not_busy <= 1'b1;
                        r_state    <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_cnt      <= '0;
                    r_bit_cnt  <= '0;
                    r_cs_n     <= 1'b1;
                    r_not_busy <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_max31855_spi_master.sv
// Bench for max31855_spi_master: a default-timing instance and a minimum-timing
// instance, each driven by a behavioural converter model that shifts a word out
// on sclk falls. Frame timing and captured data are checked against values
// derived from the frame timing rules.
module tb_max31855_spi_master;
    import thermo_spi_pkg::*;

    // Timing of instance 0 (defaults) and instance 1 (minimum)
    localparam int D0 = 2, S0 = 2, H0 = 2, I0 = 4;
    localparam int D1 = 1, S1 = 1, H1 = 1, I1 = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  ena = 2'b00;
    logic [1:0]  nb, rxd, sclk, cs_n;
    logic [1:0]  miso = 2'b00;
    logic [31:0] rx [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    max31855_spi_master #(
        .CLK_DIV(D0), .CS_SETUP(S0), .CS_HOLD(H0), .CS_IDLE(I0), .NBITS(32)
    ) dut0 (
        .clk(clk), .rst(rst), .spi_ena(ena[0]), .spi_not_busy(nb[0]),
        .spi_rx_data(rx[0]), .rx_done(rxd[0]), .sclk(sclk[0]), .cs_n(cs_n[0]),
        .miso(miso[0])
    );

    max31855_spi_master #(
        .CLK_DIV(D1), .CS_SETUP(S1), .CS_HOLD(H1), .CS_IDLE(I1), .NBITS(32)
    ) dut1 (
        .clk(clk), .rst(rst), .spi_ena(ena[1]), .spi_not_busy(nb[1]),
        .spi_rx_data(rx[1]), .rx_done(rxd[1]), .sclk(sclk[1]), .cs_n(cs_n[1]),
        .miso(miso[1])
    );

    // Reference frame lengths from the timing rules
    function automatic int busy_exp(input int k);
        return (k == 0) ? (S0 + 2 * D0 * 32 + H0 + I0) : (S1 + 2 * D1 * 32 + H1 + I1);
    endfunction

    function automatic int period_exp(input int k);
        return (k == 0) ? 2 * D0 : 2 * D1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Device model and observers, evaluated mid-cycle
    logic [31:0] dev_word [2];
    int dev_idx [2], rises [2], last_rise [2], gmin [2], gmax [2];
    int busy_run [2], last_busy [2], nb_hi [2], last_nb_hi [2];
    int cs_hi [2], last_cs_hi [2], done_cnt [2], done_rises [2], viol [2];
    logic [31:0] last_rx [2], prev_rx [2];
    logic [1:0] prev_cs = 2'b11, prev_sclk = 2'b00, prev_nb = 2'b11;
    logic prev_rst = 1'b0;
    int cyc = 0;

    initial begin
        for (int k = 0; k < 2; k++) begin
            dev_word[k] = '0; dev_idx[k] = 0; rises[k] = 0; last_rise[k] = 0;
            gmin[k] = 1000; gmax[k] = 0; busy_run[k] = 0; last_busy[k] = 0;
            nb_hi[k] = 0; last_nb_hi[k] = 0; cs_hi[k] = 0; last_cs_hi[k] = 0;
            done_cnt[k] = 0; done_rises[k] = 0; viol[k] = 0;
            last_rx[k] = '0; prev_rx[k] = '0;
        end
    end

    always @(negedge clk) begin
        int g;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (prev_cs[k] && !cs_n[k]) begin
                dev_idx[k] = 31;
                miso[k]    = dev_word[k][31];
                rises[k]   = 0;
                gmin[k]    = 1000;
                gmax[k]    = 0;
            end else if (prev_sclk[k] && !sclk[k] && !cs_n[k]) begin
                dev_idx[k] = dev_idx[k] - 1;
                if (dev_idx[k] >= 0) miso[k] = dev_word[k][dev_idx[k]];
            end
            if (!prev_sclk[k] && sclk[k]) begin
                if (rises[k] > 0) begin
                    g = cyc - last_rise[k];
                    if (g < gmin[k]) gmin[k] = g;
                    if (g > gmax[k]) gmax[k] = g;
                end
                rises[k]++;
                last_rise[k] = cyc;
            end
            if (cs_n[k]) cs_hi[k]++;
            else begin
                if (prev_cs[k]) last_cs_hi[k] = cs_hi[k];
                cs_hi[k] = 0;
            end
            if (!nb[k]) begin
                if (prev_nb[k]) last_nb_hi[k] = nb_hi[k];
                nb_hi[k] = 0;
                busy_run[k]++;
            end else begin
                if (!prev_nb[k]) last_busy[k] = busy_run[k];
                busy_run[k] = 0;
                nb_hi[k]++;
            end
            if (rxd[k]) begin
                done_cnt[k]++;
                last_rx[k]    = rx[k];
                done_rises[k] = rises[k];
            end else if (rst && prev_rst && rx[k] !== prev_rx[k]) begin
                viol[k]++;
            end
            prev_rx[k] = rx[k];
        end
        prev_cs   = cs_n;
        prev_sclk = sclk;
        prev_nb   = nb;
        prev_rst  = rst;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int k);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (nb[k]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 0, 1);
        step();
    endtask

    task automatic run_frame(input int k, input logic [31:0] w);
        int d0;
        d0 = done_cnt[k];
        dev_word[k] = w;
        ena[k] = 1'b1;
        step();
        ena[k] = 1'b0;
        chk("busy_after_req", nb[k], 0);
        wait_idle(k);
        chk("busy_len", last_busy[k], busy_exp(k));
        chk("sclk_rises", done_rises[k], 32);
        chk("done_once", done_cnt[k] - d0, 1);
        chk("rx_at_done", last_rx[k], w);
        chk("rx_held", rx[k], w);
    endtask

    initial begin
        int d0;
        bit ok;
        logic [31:0] w3 [3];

        // Reset state
        repeat (4) step();
        for (int k = 0; k < 2; k++) begin
            chk("rst_not_busy", nb[k], 1);
            chk("rst_cs_n", cs_n[k], 1);
            chk("rst_sclk", sclk[k], 0);
            chk("rst_rx", rx[k], 0);
            chk("rst_done", rxd[k], 0);
        end
        rst = 1'b1;
        repeat (3) step();

        // Basic frame and sclk period
        run_frame(0, 32'hA5A51234);
        chk("sclk_period_min", gmin[0], period_exp(0));
        chk("sclk_period_max", gmax[0], period_exp(0));

        // Fault bits reach their field positions
        run_frame(0, 32'h00010007);
        chk("fault_field", fault_bits(last_rx[0]), 4'b1111);

        // Back-to-back frames with the request held high
        w3[0] = 32'h11111111; w3[1] = 32'h22222222; w3[2] = 32'h33333333;
        d0 = done_cnt[0];
        dev_word[0] = w3[0];
        ena[0] = 1'b1;
        for (int f = 0; f < 3; f++) begin
            ok = 1'b0;
            for (int i = 0; i < 400; i++) begin
                step();
                if (done_cnt[0] > d0 + f) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) chk("b2b_timeout", 0, 1);
            chk("b2b_rx", last_rx[0], w3[f]);
            if (f < 2) dev_word[0] = w3[f+1];
            else ena[0] = 1'b0;
            if (f > 0) begin
                chk("b2b_idle_1cyc", last_nb_hi[0], 1);
                chk("b2b_cs_gap", last_cs_hi[0] >= I0, 1);
            end
        end
        wait_idle(0);
        repeat (10) step();
        chk("b2b_frames", done_cnt[0] - d0, 3);
        chk("b2b_stays_idle", nb[0], 1);

        // Requests during a busy frame are ignored
        d0 = done_cnt[0];
        dev_word[0] = $urandom;
        ena[0] = 1'b1;
        step();
        ena[0] = 1'b0;
        ok = 1'b0;
        for (int c = 1; c < 2000; c++) begin
            ena[0] = (c == 10 || c == 50 || c == 100);
            step();
            if (nb[0]) begin
                ok = 1'b1;
                break;
            end
        end
        ena[0] = 1'b0;
        if (!ok) chk("ignore_timeout", 0, 1);
        step();
        chk("ignore_busy_len", last_busy[0], busy_exp(0));
        chk("ignore_rises", done_rises[0], 32);
        chk("ignore_rx", last_rx[0], dev_word[0]);
        repeat (20) step();
        chk("ignore_no_extra", done_cnt[0] - d0, 1);
        chk("ignore_idle", nb[0], 1);

        // Reset in the middle of a frame
        d0 = done_cnt[0];
        dev_word[0] = 32'hDEADBEEF;
        ena[0] = 1'b1;
        step();
        ena[0] = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (rises[0] >= 16) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("mid_rst_timeout", 0, 1);
        step();
        rst = 1'b0;
        step();
        chk("mid_rst_cs_n", cs_n[0], 1);
        chk("mid_rst_sclk", sclk[0], 0);
        chk("mid_rst_not_busy", nb[0], 1);
        chk("mid_rst_rx", rx[0], 0);
        chk("mid_rst_done", rxd[0], 0);
        rst = 1'b1;
        repeat (5) step();
        chk("mid_rst_no_done", done_cnt[0] - d0, 0);
        chk("mid_rst_rx_kept", rx[0], 0);
        run_frame(0, $urandom);

        // Minimum timing instance
        run_frame(1, 32'h80000001);
        chk("fast_period_min", gmin[1], period_exp(1));
        chk("fast_period_max", gmax[1], period_exp(1));

        // Randomized frames on both instances
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 7)) step();
            run_frame(0, $urandom);
            repeat ($urandom_range(0, 7)) step();
            run_frame(1, $urandom);
        end

        chk("rx_stable_0", viol[0], 0);
        chk("rx_stable_1", viol[1], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
